// File: rtl/ctrl_pkg.sv
// Shared encodings for the CR-16-style multicycle controller.
package ctrl_pkg;

    localparam int unsigned OP_W    = 4;
    localparam int unsigned STATE_W = 4;

    // Primary opcodes (instr[15:12])
    localparam logic [OP_W-1:0] OP_RTYPE = 4'b0000;
    localparam logic [OP_W-1:0] OP_ANDI  = 4'b0001;
    localparam logic [OP_W-1:0] OP_ORI   = 4'b0010;
    localparam logic [OP_W-1:0] OP_XORI  = 4'b0011;
    localparam logic [OP_W-1:0] OP_MEMJ  = 4'b0100;
    localparam logic [OP_W-1:0] OP_ADDI  = 4'b0101;
    localparam logic [OP_W-1:0] OP_SUBI  = 4'b1001;
    localparam logic [OP_W-1:0] OP_CMPI  = 4'b1011;
    localparam logic [OP_W-1:0] OP_BCOND = 4'b1100;
    localparam logic [OP_W-1:0] OP_MOVI  = 4'b1101;

    // Extensions (instr[7:4]) for the R-type group
    localparam logic [OP_W-1:0] EXT_AND = 4'b0001;
    localparam logic [OP_W-1:0] EXT_OR  = 4'b0010;
    localparam logic [OP_W-1:0] EXT_XOR = 4'b0011;
    localparam logic [OP_W-1:0] EXT_ADD = 4'b0101;
    localparam logic [OP_W-1:0] EXT_SUB = 4'b1001;
    localparam logic [OP_W-1:0] EXT_CMP = 4'b1011;
    localparam logic [OP_W-1:0] EXT_MOV = 4'b1101;

    // Extensions for the memory/jump group
    localparam logic [OP_W-1:0] EXT_LOAD  = 4'b0000;
    localparam logic [OP_W-1:0] EXT_STOR  = 4'b0100;
    localparam logic [OP_W-1:0] EXT_JCOND = 4'b1100;

    // Condition codes
    localparam logic [OP_W-1:0] CC_EQ = 4'h0;
    localparam logic [OP_W-1:0] CC_NE = 4'h1;
    localparam logic [OP_W-1:0] CC_CS = 4'h2;
    localparam logic [OP_W-1:0] CC_CC = 4'h3;
    localparam logic [OP_W-1:0] CC_HI = 4'h4;
    localparam logic [OP_W-1:0] CC_LS = 4'h5;
    localparam logic [OP_W-1:0] CC_GT = 4'h6;
    localparam logic [OP_W-1:0] CC_LE = 4'h7;
    localparam logic [OP_W-1:0] CC_FS = 4'h8;
    localparam logic [OP_W-1:0] CC_FC = 4'h9;
    localparam logic [OP_W-1:0] CC_LO = 4'hA;
    localparam logic [OP_W-1:0] CC_HS = 4'hB;
    localparam logic [OP_W-1:0] CC_LT = 4'hC;
    localparam logic [OP_W-1:0] CC_GE = 4'hD;
    localparam logic [OP_W-1:0] CC_UC = 4'hE;
    localparam logic [OP_W-1:0] CC_NV = 4'hF;

    // Flag bit positions in {N,Z,F,L,C}
    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_L = 1;
    localparam int unsigned FLAG_F = 2;
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 4;

    // Mux select encodings
    localparam logic       PC_S_RSRC   = 1'b0;
    localparam logic       PC_S_ALU    = 1'b1;
    localparam logic       MEM_S_RDEST = 1'b0;
    localparam logic       MEM_S_PC    = 1'b1;
    localparam logic [1:0] WD_S_IMM    = 2'b00;
    localparam logic [1:0] WD_S_RSRC   = 2'b01;
    localparam logic [1:0] WD_S_MEM    = 2'b10;
    localparam logic [1:0] WD_S_ALU    = 2'b11;
    localparam logic [1:0] ALUA_S_RSRC = 2'b00;
    localparam logic [1:0] ALUA_S_PC   = 2'b01;
    localparam logic [1:0] ALUA_S_IMM  = 2'b10;
    localparam logic [1:0] ALUA_S_ZERO = 2'b11;
    localparam logic [1:0] ALUB_S_RDEST = 2'b00;
    localparam logic [1:0] ALUB_S_IMM   = 2'b01;
    localparam logic [1:0] ALUB_S_ONE   = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_FETCH2 = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_WB     = 4'd4,
        S_MOVE   = 4'd5,
        S_LD_RD  = 4'd6,
        S_LD_WB  = 4'd7,
        S_STORE  = 4'd8,
        S_BR_ADD = 4'd9,
        S_BR_PC  = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

endpackage

// File: rtl/cond_check.sv
// Branch/jump condition evaluation against the PSR flags.
module cond_check
    import ctrl_pkg::*;
#(
    parameter int unsigned OPW   = 4,
    parameter int unsigned FLAGW = 5
) (
    input  logic [OPW-1:0]   cond,
    input  logic [FLAGW-1:0] flags,
    output logic             taken
);

    logic n_f, z_f, f_f, l_f, c_f;

    assign n_f = flags[FLAG_N];
    assign z_f = flags[FLAG_Z];
    assign f_f = flags[FLAG_F];
    assign l_f = flags[FLAG_L];
    assign c_f = flags[FLAG_C];

    // Condition table lookup
    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_EQ: taken = z_f;
            CC_NE: taken = !z_f;
            CC_CS: taken = c_f;
            CC_CC: taken = !c_f;
            CC_HI: taken = l_f;
            CC_LS: taken = !l_f;
            CC_GT: taken = n_f;
            CC_LE: taken = !n_f;
            CC_FS: taken = f_f;
            CC_FC: taken = !f_f;
            CC_LO: taken = !l_f && !z_f;
            CC_HS: taken = l_f || z_f;
            CC_LT: taken = !n_f && !z_f;
            CC_GE: taken = n_f || z_f;
            CC_UC: taken = 1'b1;
            CC_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/mcu_controller.sv
// Multicycle Moore control FSM for the 16-bit CR-16-style datapath.
module mcu_controller
    import ctrl_pkg::*;
#(
    parameter int unsigned OPW   = 4,
    parameter int unsigned FLAGW = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPW-1:0]   op_code,
    input  logic [OPW-1:0]   op_ext,
    input  logic [OPW-1:0]   cond,
    input  logic [FLAGW-1:0] flags,
    output logic             pc_s,
    output logic             mem_s,
    output logic [1:0]       wd_s,
    output logic [1:0]       alua_s,
    output logic [1:0]       alub_s,
    output logic             sign_ext_s,
    output logic             alu_add,
    output logic             pc_en,
    output logic             inst_en,
    output logic             alu_out_en,
    output logic             mem_reg_en,
    output logic             regwrite,
    output logic             flag_en,
    output logic             mem_we
);

    state_t state, state_nxt;
    logic   taken;

    logic is_r, r_alu, r_mov, r_flag, r_cmp;
    logic i_alu, i_sext, i_cmp, i_movi;
    logic is_load, is_stor, is_jcond, is_bcond;

    cond_check #(.OPW(OPW), .FLAGW(FLAGW)) u_cond (
        .cond  (cond),
        .flags (flags),
        .taken (taken)
    );

    // Instruction class decode from the held instruction fields
    always_comb begin
        is_r     = (op_code == OP_RTYPE);
        r_alu    = is_r && (op_ext == EXT_AND || op_ext == EXT_OR  || op_ext == EXT_XOR ||
                            op_ext == EXT_ADD || op_ext == EXT_SUB || op_ext == EXT_CMP);
        r_mov    = is_r && (op_ext == EXT_MOV);
        r_flag   = is_r && (op_ext == EXT_ADD || op_ext == EXT_SUB || op_ext == EXT_CMP);
        r_cmp    = is_r && (op_ext == EXT_CMP);
        i_sext   = (op_code == OP_ADDI) || (op_code == OP_SUBI) || (op_code == OP_CMPI);
        i_alu    = i_sext || (op_code == OP_ANDI) || (op_code == OP_ORI) || (op_code == OP_XORI);
        i_cmp    = (op_code == OP_CMPI);
        i_movi   = (op_code == OP_MOVI);
        is_load  = (op_code == OP_MEMJ) && (op_ext == EXT_LOAD);
        is_stor  = (op_code == OP_MEMJ) && (op_ext == EXT_STOR);
        is_jcond = (op_code == OP_MEMJ) && (op_ext == EXT_JCOND);
        is_bcond = (op_code == OP_BCOND);
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = S_FETCH2;
            S_FETCH2: state_nxt = S_DECODE;
            S_DECODE: begin
                if (r_alu || i_alu)       state_nxt = S_EXEC;
                else if (r_mov || i_movi) state_nxt = S_MOVE;
                else if (is_load)         state_nxt = S_LD_RD;
                else if (is_stor)         state_nxt = S_STORE;
                else if (is_bcond)        state_nxt = taken ? S_BR_ADD : S_FETCH;
                else if (is_jcond)        state_nxt = taken ? S_JUMP : S_FETCH;
                else                      state_nxt = S_FETCH;
            end
            S_EXEC:   state_nxt = (r_cmp || i_cmp) ? S_FETCH : S_WB;
            S_LD_RD:  state_nxt = S_LD_WB;
            S_BR_ADD: state_nxt = S_BR_PC;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // Output decode; write enables and strobes are suppressed during reset
    always_comb begin
        pc_s       = PC_S_RSRC;
        mem_s      = MEM_S_RDEST;
        wd_s       = WD_S_IMM;
        alua_s     = ALUA_S_RSRC;
        alub_s     = ALUB_S_RDEST;
        sign_ext_s = 1'b0;
        alu_add    = 1'b0;
        pc_en      = 1'b0;
        inst_en    = 1'b0;
        alu_out_en = 1'b0;
        mem_reg_en = 1'b0;
        regwrite   = 1'b0;
        flag_en    = 1'b0;
        mem_we     = 1'b0;
        case (state)
            S_FETCH:  mem_s = MEM_S_PC;
            S_FETCH2: begin
                inst_en    = 1'b1;
                mem_s      = MEM_S_PC;
                alua_s     = ALUA_S_PC;
                alub_s     = ALUB_S_ONE;
                alu_add    = 1'b1;
                alu_out_en = 1'b1;
            end
            S_DECODE: begin
                pc_s  = PC_S_ALU;
                pc_en = 1'b1;
            end
            S_EXEC: begin
                alua_s     = ALUA_S_RSRC;
                alub_s     = is_r ? ALUB_S_RDEST : ALUB_S_IMM;
                alu_out_en = 1'b1;
                flag_en    = r_flag || i_sext;
                sign_ext_s = i_sext;
            end
            S_WB: begin
                wd_s     = WD_S_ALU;
                regwrite = 1'b1;
            end
            S_MOVE: begin
                regwrite = 1'b1;
                wd_s     = r_mov ? WD_S_RSRC : WD_S_IMM;
            end
            S_LD_RD: begin
                mem_s      = MEM_S_RDEST;
                mem_reg_en = 1'b1;
            end
            S_LD_WB: begin
                wd_s     = WD_S_MEM;
                regwrite = 1'b1;
            end
            S_STORE: begin
                mem_s  = MEM_S_RDEST;
                mem_we = 1'b1;
            end
            S_BR_ADD: begin
                alua_s     = ALUA_S_PC;
                alub_s     = ALUB_S_IMM;
                sign_ext_s = 1'b1;
                alu_add    = 1'b1;
                alu_out_en = 1'b1;
            end
            S_BR_PC: begin
                pc_s  = PC_S_ALU;
                pc_en = 1'b1;
            end
            S_JUMP: begin
                pc_s  = PC_S_RSRC;
                pc_en = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            pc_en    = 1'b0;
            inst_en  = 1'b0;
            regwrite = 1'b0;
            flag_en  = 1'b0;
            mem_we   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mcu_controller.sv
// Directed bench for mcu_controller: per-cycle output vectors against hand-built expectations.
module tb_mcu_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] op_code, op_ext, cond;
    logic [4:0] flags;
    logic       pc_s, mem_s, sign_ext_s, alu_add;
    logic [1:0] wd_s, alua_s, alub_s;
    logic       pc_en, inst_en, alu_out_en, mem_reg_en, regwrite, flag_en, mem_we;

    mcu_controller #(.OPW(4), .FLAGW(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .op_code    (op_code),
        .op_ext     (op_ext),
        .cond       (cond),
        .flags      (flags),
        .pc_s       (pc_s),
        .mem_s      (mem_s),
        .wd_s       (wd_s),
        .alua_s     (alua_s),
        .alub_s     (alub_s),
        .sign_ext_s (sign_ext_s),
        .alu_add    (alu_add),
        .pc_en      (pc_en),
        .inst_en    (inst_en),
        .alu_out_en (alu_out_en),
        .mem_reg_en (mem_reg_en),
        .regwrite   (regwrite),
        .flag_en    (flag_en),
        .mem_we     (mem_we)
    );

    always #5 clk = ~clk;

    // {pc_s, mem_s, wd_s, alua_s, alub_s, sign_ext_s, alu_add,
    //  pc_en, inst_en, alu_out_en, mem_reg_en, regwrite, flag_en, mem_we}
    logic [16:0] outs;
    logic [4:0]  strobes;
    assign outs = {pc_s, mem_s, wd_s, alua_s, alub_s, sign_ext_s, alu_add,
                   pc_en, inst_en, alu_out_en, mem_reg_en, regwrite, flag_en, mem_we};
    assign strobes = {pc_en, inst_en, regwrite, flag_en, mem_we};

    localparam logic [16:0] V_FETCH   = {1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 7'b0000000};
    localparam logic [16:0] V_FETCH2  = {1'b0, 1'b1, 2'd0, 2'd1, 2'd2, 1'b0, 1'b1, 7'b0110000};
    localparam logic [16:0] V_DECODE  = {1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 7'b1000000};
    localparam logic [16:0] V_EX_RF   = {1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 7'b0010010};
    localparam logic [16:0] V_EX_R    = {1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 7'b0010000};
    localparam logic [16:0] V_EX_IS   = {1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 1'b1, 1'b0, 7'b0010010};
    localparam logic [16:0] V_EX_IZ   = {1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 7'b0010000};
    localparam logic [16:0] V_WB      = {1'b0, 1'b0, 2'd3, 2'd0, 2'd0, 1'b0, 1'b0, 7'b0000100};
    localparam logic [16:0] V_MOV     = {1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 7'b0000100};
    localparam logic [16:0] V_MOVI    = {1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 7'b0000100};
    localparam logic [16:0] V_LD_RD   = {1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 7'b0001000};
    localparam logic [16:0] V_LD_WB   = {1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 7'b0000100};
    localparam logic [16:0] V_STORE   = {1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 7'b0000001};
    localparam logic [16:0] V_BR_ADD  = {1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 1'b1, 1'b1, 7'b0010000};
    localparam logic [16:0] V_BR_PC   = V_DECODE;
    localparam logic [16:0] V_JUMP    = {1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 7'b1000000};
    localparam logic [16:0] V_DEC_RST = {1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 7'b0000000};
    localparam logic [16:0] V_F2_RST  = {1'b0, 1'b1, 2'd0, 2'd1, 2'd2, 1'b0, 1'b1, 7'b0010000};

    int n_checks = 0;
    int n_fail   = 0;

    logic [16:0] seq [8];
    int          seq_len;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic load_seq(input int n, input logic [16:0] a, input logic [16:0] b,
                            input logic [16:0] c, input logic [16:0] d, input logic [16:0] e);
        seq_len = n;
        seq[0] = a; seq[1] = b; seq[2] = c; seq[3] = d; seq[4] = e;
    endtask

    // Runs one instruction from FETCH, checking every cycle; leaves the FSM at the next FETCH.
    task automatic run(input string tag, input logic [15:0] instr, input logic [4:0] flg);
        op_code = instr[15:12];
        cond    = instr[11:8];
        op_ext  = instr[7:4];
        flags   = flg;
        #1;
        for (int i = 0; i < seq_len; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            check_eq($sformatf("%s[%0d]", tag, i), 32'(outs), 32'(seq[i]));
        end
        @(negedge clk);
    endtask

    // Condition truth table with flags {N,Z,F,L,C}
    function automatic logic exp_taken(input logic [3:0] c, input logic [4:0] f);
        logic n, z, ff, l, cy;
        n = f[4]; z = f[3]; ff = f[2]; l = f[1]; cy = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return l;
            4'h5: return !l;
            4'h6: return n;
            4'h7: return !n;
            4'h8: return ff;
            4'h9: return !ff;
            4'hA: return !l && !z;
            4'hB: return l || z;
            4'hC: return !n && !z;
            4'hD: return n || z;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; op_code = 4'h0; op_ext = 4'h0; cond = 4'h0; flags = 5'h0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("reset_outs", 32'(outs), 32'(V_FETCH));
        reset = 1'b0;

        // ADD R1,R2 then R-type SUB, XOR, MOV
        load_seq(5, V_FETCH, V_FETCH2, V_DECODE, V_EX_RF, V_WB);
        run("add", 16'h0152, 5'h00);
        run("sub", 16'h0192, 5'h00);
        load_seq(5, V_FETCH, V_FETCH2, V_DECODE, V_EX_R, V_WB);
        run("xor", 16'h0132, 5'h00);
        load_seq(4, V_FETCH, V_FETCH2, V_DECODE, V_MOV, 17'h0);
        run("mov", 16'h03D2, 5'h00);

        // CMPI then BEQ taken / untaken
        load_seq(4, V_FETCH, V_FETCH2, V_DECODE, V_EX_IS, 17'h0);
        run("cmpi", 16'hB105, 5'h00);
        load_seq(5, V_FETCH, V_FETCH2, V_DECODE, V_BR_ADD, V_BR_PC);
        run("beq_t", 16'hC0FE, 5'b01000);
        load_seq(3, V_FETCH, V_FETCH2, V_DECODE, 17'h0, 17'h0);
        run("beq_nt", 16'hC0FE, 5'b10111);

        // Immediate forms: ADDI with writeback, ORI zero-extended
        load_seq(5, V_FETCH, V_FETCH2, V_DECODE, V_EX_IS, V_WB);
        run("addi", 16'h5107, 5'h00);
        load_seq(5, V_FETCH, V_FETCH2, V_DECODE, V_EX_IZ, V_WB);
        run("ori", 16'h21F0, 5'h00);

        // LOAD / STOR
        load_seq(5, V_FETCH, V_FETCH2, V_DECODE, V_LD_RD, V_LD_WB);
        run("load", 16'h4102, 5'h00);
        load_seq(4, V_FETCH, V_FETCH2, V_DECODE, V_STORE, 17'h0);
        run("stor", 16'h4142, 5'h00);

        // MOVI and illegal opcodes
        load_seq(4, V_FETCH, V_FETCH2, V_DECODE, V_MOVI, 17'h0);
        run("movi", 16'hD3FF, 5'h00);
        load_seq(3, V_FETCH, V_FETCH2, V_DECODE, 17'h0, 17'h0);
        run("illegal7", 16'h7123, 5'h1F);
        run("illegal_r", 16'h0172, 5'h00);
        run("illegal_m", 16'h4182, 5'h00);

        // All conditions against all flag values via Jcond
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 32; f++) begin
                if (exp_taken(4'(c), 5'(f)))
                    load_seq(4, V_FETCH, V_FETCH2, V_DECODE, V_JUMP, 17'h0);
                else
                    load_seq(3, V_FETCH, V_FETCH2, V_DECODE, 17'h0, 17'h0);
                run($sformatf("jcond_c%0d_f%0d", c, f), {4'h4, 4'(c), 4'hC, 4'h0}, 5'(f));
            end
        end

        // Reset mid-LOAD, asserted in LD_RD
        op_code = 4'h4; cond = 4'h1; op_ext = 4'h0; flags = 5'h0;
        #1;
        check_eq("ldrst_fetch", 32'(outs), 32'(V_FETCH));
        @(negedge clk); #1;
        check_eq("ldrst_fetch2", 32'(outs), 32'(V_FETCH2));
        @(negedge clk); #1;
        check_eq("ldrst_decode", 32'(outs), 32'(V_DECODE));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("ldrst_ldrd", 32'(outs), 32'(V_LD_RD));
        check_eq("ldrst_strobes", 32'(strobes), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("ldrst_back_fetch", 32'(outs), 32'(V_FETCH));
        @(negedge clk); #1;
        check_eq("ldrst_no_ldwb", 32'(outs), 32'(V_FETCH2));
        @(negedge clk); #1;

        // Reset asserted in DECODE: pc_en suppressed, select unchanged
        reset = 1'b1;
        #1;
        check_eq("decrst_outs", 32'(outs), 32'(V_DEC_RST));
        @(negedge clk);
        #1;
        check_eq("decrst_fetch", 32'(outs), 32'(V_FETCH));
        // Reset held one more cycle: stays in FETCH
        @(negedge clk);
        #1;
        check_eq("rst_hold_fetch", 32'(outs), 32'(V_FETCH));
        reset = 1'b0;
        @(negedge clk); #1;

        // Reset asserted in FETCH2: inst_en suppressed
        reset = 1'b1;
        #1;
        check_eq("f2rst_outs", 32'(outs), 32'(V_F2_RST));
        @(negedge clk);
        reset = 1'b0;

        // Normal operation resumes after reset
        load_seq(5, V_FETCH, V_FETCH2, V_DECODE, V_EX_RF, V_WB);
        run("add_after_rst", 16'h0152, 5'h00);
        load_seq(1, V_FETCH, 17'h0, 17'h0, 17'h0, 17'h0);
        run("final_fetch", 16'h0000, 5'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
